// File: rtl/lsu_mcycle.sv
// lsu_mcycle: multi-cycle load/store unit sitting between EXU and WBU.
// One op is taken per valid/ready handshake and issued on a req/gnt + rvalid
// data-memory port. Loads are lane-aligned and sign/zero-extended. Stalls on
// gnt or rvalid end in an error once the timer runs out.
// Build option: define LSU_MISALIGN_EXC_EN to reject misaligned accesses
// with o_err before they reach memory. When it is undefined, misaligned ops
// are issued and any lanes past the word boundary are dropped.
//
// state  | meaning
// -------+----------------------------------------------------------
// S_IDLE | ready for a new op from EXU
// S_REQ  | o_mem_req high, address/data/strobes held until gnt
// S_WAIT | load granted, waiting for rvalid
// S_DONE | result valid toward WBU, held until i_ready
module lsu_mcycle #(
  parameter int CPU_WIDTH = 64,
  parameter int TIMEOUT   = 255
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [2:0]             i_lsfunc3,
  input  logic                   i_lden,
  input  logic                   i_sten,
  input  logic [CPU_WIDTH-1:0]   i_addr,
  input  logic [CPU_WIDTH-1:0]   i_regst,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [CPU_WIDTH-1:0]   o_regld,
  output logic                   o_err,
  output logic                   o_mem_req,
  input  logic                   i_mem_gnt,
  output logic                   o_mem_we,
  output logic [CPU_WIDTH-1:0]   o_mem_addr,
  output logic [CPU_WIDTH-1:0]   o_mem_wdata,
  output logic [CPU_WIDTH/8-1:0] o_mem_wstrb,
  input  logic                   i_mem_rvalid,
  input  logic [CPU_WIDTH-1:0]   i_mem_rdata
);

  localparam int NBYTE = CPU_WIDTH / 8;
  localparam int OFFW  = $clog2(NBYTE);
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t          state;
  logic [2:0]      r_fn;
  logic [OFFW-1:0] r_off;
  logic            r_ld;
  logic [TW-1:0]   timer;

  logic [2:0]      fn_eff;
  logic [OFFW-1:0] in_off;
  logic [NBYTE-1:0] size_mask;
  logic            is_mem;

  assign in_off  = i_addr[OFFW-1:0];
  assign is_mem  = i_lden | i_sten;
  assign o_ready = (state == S_IDLE);

  // Sign- or zero-extend the already lane-shifted load word according to func3.
  function automatic logic [CPU_WIDTH-1:0] extend_load(input logic [2:0] fn,
                                                       input logic [CPU_WIDTH-1:0] s);
    case (fn)
      3'b000:  return CPU_WIDTH'($signed(s[7:0]));
      3'b001:  return CPU_WIDTH'($signed(s[15:0]));
      3'b010:  return CPU_WIDTH'($signed(s[31:0]));
      3'b100:  return CPU_WIDTH'(s[7:0]);
      3'b101:  return CPU_WIDTH'(s[15:0]);
      3'b110:  return CPU_WIDTH'(s[31:0]);
      default: return s;
    endcase
  endfunction

  // Decode access size; on a 32-bit datapath, D and WU collapse to W.
  always_comb begin
    fn_eff = i_lsfunc3;
    if (CPU_WIDTH == 32 && (i_lsfunc3[1:0] == 2'b11 || i_lsfunc3 == 3'b110))
      fn_eff = 3'b010;
    case (fn_eff[1:0])
      2'b00:   size_mask = NBYTE'(1);
      2'b01:   size_mask = NBYTE'(3);
      2'b10:   size_mask = NBYTE'(15);
      default: size_mask = '1;
    endcase
  end

`ifdef LSU_MISALIGN_EXC_EN
  logic misaligned;

  // An access is misaligned when any offset bit below its size is set.
  always_comb begin
    case (fn_eff[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = in_off[0];
      2'b10:   misaligned = |in_off[1:0];
      default: misaligned = |in_off;
    endcase
  end
`endif

  // Control FSM with registered memory-port and result outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_IDLE;
      r_fn        <= '0;
      r_off       <= '0;
      r_ld        <= 1'b0;
      timer       <= '0;
      o_valid     <= 1'b0;
      o_regld     <= '0;
      o_err       <= 1'b0;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_wstrb <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_valid) begin
            r_fn        <= fn_eff;
            r_off       <= in_off;
            r_ld        <= i_lden;
            timer       <= '0;
            o_regld     <= '0;
            o_err       <= 1'b0;
            o_mem_we    <= i_sten & ~i_lden;
            o_mem_addr  <= {i_addr[CPU_WIDTH-1:OFFW], OFFW'(0)};
            o_mem_wdata <= i_regst << {in_off, 3'b000};
            // func3 1xx has no store meaning: write no bytes.
            o_mem_wstrb <= (i_sten & ~i_lden & ~fn_eff[2]) ? (size_mask << in_off) : '0;
            if (!is_mem) begin
              state   <= S_DONE;
              o_valid <= 1'b1;
            end
`ifdef LSU_MISALIGN_EXC_EN
            else if (misaligned) begin
              state   <= S_DONE;
              o_valid <= 1'b1;
              o_err   <= 1'b1;
            end
`endif
            else begin
              state     <= S_REQ;
              o_mem_req <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (i_mem_gnt) begin
            o_mem_req <= 1'b0;
            timer     <= '0;
            if (r_ld) begin
              state <= S_WAIT;
            end else begin
              state   <= S_DONE;
              o_valid <= 1'b1;
            end
          end else if (timer == TIMER_LAST) begin
            o_mem_req <= 1'b0;
            o_err     <= 1'b1;
            o_regld   <= '0;
            state     <= S_DONE;
            o_valid   <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_WAIT: begin
          if (i_mem_rvalid) begin
            o_regld <= extend_load(r_fn, i_mem_rdata >> {r_off, 3'b000});
            state   <= S_DONE;
            o_valid <= 1'b1;
          end else if (timer == TIMER_LAST) begin
            o_err   <= 1'b1;
            o_regld <= '0;
            state   <= S_DONE;
            o_valid <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
